// File: rtl/arith_pkg.sv
// Shared definitions for the sequential arithmetic examples (multiplier/divider).
package arith_pkg;

  localparam int unsigned DIV_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/divide_seq_div_step.sv
// One restoring shift-subtract step: shift in the next dividend bit, trial-subtract
// the divisor, keep the difference only when it did not borrow.
module div_step
  import arith_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] r_w,
  input  logic             q_msb,
  input  logic [WIDTH-1:0] d_w,
  output logic [WIDTH-1:0] r_next,
  output logic             q_bit
);

  logic [WIDTH:0] s;
  logic [WIDTH:0] t;

  always_comb begin
    s      = {r_w, q_msb};
    t      = s - {1'b0, d_w};
    q_bit  = ~t[WIDTH];
    r_next = q_bit ? t[WIDTH-1:0] : s[WIDTH-1:0];
  end

endmodule

// File: rtl/divide_seq.sv
// Sequential restoring divider: one quotient bit per clock, WIDTH cycles from accept
// to fin; divide-by-zero completes in the accept cycle with dbz set.
module divide_seq
  import arith_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             fin,
  output logic             dbz,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  div_state_e       state_q, state_d;
  logic [WIDTH-1:0] q_w_q, q_w_d;
  logic [WIDTH-1:0] r_w_q, r_w_d;
  logic [WIDTH-1:0] d_w_q, d_w_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             fin_q, fin_d;
  logic             dbz_q, dbz_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;

  logic [WIDTH-1:0] step_r;
  logic             step_q;
  logic [WIDTH-1:0] q_shift;

  div_step #(.WIDTH(WIDTH)) u_step (
    .r_w    (r_w_q),
    .q_msb  (q_w_q[WIDTH-1]),
    .d_w    (d_w_q),
    .r_next (step_r),
    .q_bit  (step_q)
  );

  always_comb begin
    state_d     = state_q;
    q_w_d       = q_w_q;
    r_w_d       = r_w_q;
    d_w_d       = d_w_q;
    cnt_d       = cnt_q;
    busy_d      = busy_q;
    fin_d       = fin_q;
    dbz_d       = dbz_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    q_shift     = {q_w_q[WIDTH-2:0], step_q};

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          if (divisor == '0) begin
            quotient_d  = '1;
            remainder_d = dividend;
            dbz_d       = 1'b1;
            fin_d       = 1'b1;
            busy_d      = 1'b0;
            state_d     = DONE;
          end else begin
            q_w_d   = dividend;
            r_w_d   = '0;
            d_w_d   = divisor;
            cnt_d   = CNT_LOAD;
            busy_d  = 1'b1;
            fin_d   = 1'b0;
            dbz_d   = 1'b0;
            state_d = RUN;
          end
        end
      end
      RUN: begin
        r_w_d = step_r;
        q_w_d = q_shift;
        cnt_d = cnt_q - CNT_ONE;
        // Final iteration publishes straight from the step, not from q_w/r_w.
        if (cnt_q == CNT_ONE) begin
          quotient_d  = q_shift;
          remainder_d = step_r;
          fin_d       = 1'b1;
          busy_d      = 1'b0;
          state_d     = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      q_w_q       <= '0;
      r_w_q       <= '0;
      d_w_q       <= '0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      fin_q       <= 1'b0;
      dbz_q       <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
    end else begin
      state_q     <= state_d;
      q_w_q       <= q_w_d;
      r_w_q       <= r_w_d;
      d_w_q       <= d_w_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      fin_q       <= fin_d;
      dbz_q       <= dbz_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
    end
  end

  assign busy      = busy_q;
  assign fin       = fin_q;
  assign dbz       = dbz_q;
  assign quotient  = quotient_q;
  assign remainder = remainder_q;

endmodule

// File: tb/tb_divide_seq.sv
// Self-checking bench for divide_seq against a plain / and % reference.
module tb_divide_seq;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         fin;
  logic         dbz;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  divide_seq #(.WIDTH(W), .CNT_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .fin       (fin),
    .dbz       (dbz),
    .quotient  (quotient),
    .remainder (remainder)
  );

  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] q, output logic [W-1:0] r,
                                output logic z);
    if (b == 0) begin
      q = '1; r = a; z = 1'b1;
    end else begin
      q = a / b; r = a % b; z = 1'b0;
    end
  endfunction

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    start = 1'b1; dividend = a; divisor = b;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_fin(input int limit, output int cycles, output bit timeout);
    cycles = 0;
    while (fin !== 1'b1 && cycles < limit) begin
      @(posedge clk); #1;
      cycles++;
    end
    timeout = (fin !== 1'b1);
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b1; dividend = 182; divisor = 13;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy, fin, dbz} !== 3'b000) begin
      errors++; $display("FAIL reset_flags: got %b expected 000", {busy, fin, dbz});
    end
    checks++;
    if (quotient !== '0 || remainder !== '0) begin
      errors++; $display("FAIL reset_data: got q=%0h r=%0h expected 0/0", quotient, remainder);
    end
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
  endtask

  task automatic test_basic();
    int cyc; bit to;
    issue(182, 13);
    checks++;
    if (busy !== 1'b1 || fin !== 1'b0) begin
      errors++; $display("FAIL basic_accept: got busy=%b fin=%b expected 1/0", busy, fin);
    end
    wait_fin(100, cyc, to);
    checks++;
    if (to || cyc != W) begin
      errors++; $display("FAIL basic_latency: got %0d cycles (timeout=%0d) expected %0d", cyc, to, W);
    end
    checks++;
    if (quotient !== 14 || remainder !== 0 || dbz !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL basic_result: got q=%0d r=%0d dbz=%b busy=%b expected 14/0/0/0",
                         quotient, remainder, dbz, busy);
    end
  endtask

  task automatic test_small();
    int cyc; bit to;
    issue(100, 7);
    wait_fin(100, cyc, to);
    checks++;
    if (to || quotient !== 14 || remainder !== 2) begin
      errors++; $display("FAIL small_100_7: got q=%0d r=%0d timeout=%0d expected 14/2", quotient, remainder, to);
    end
    issue(5, 9);
    wait_fin(100, cyc, to);
    checks++;
    if (to || quotient !== 0 || remainder !== 5) begin
      errors++; $display("FAIL small_5_9: got q=%0d r=%0d timeout=%0d expected 0/5", quotient, remainder, to);
    end
  endtask

  task automatic test_dbz();
    bit saw_busy;
    issue(55, 0);
    checks++;
    if (fin !== 1'b1 || dbz !== 1'b1) begin
      errors++; $display("FAIL dbz_flags: got fin=%b dbz=%b expected 1/1", fin, dbz);
    end
    checks++;
    if (quotient !== 32'hFFFF_FFFF || remainder !== 55) begin
      errors++; $display("FAIL dbz_data: got q=%0h r=%0d expected ffffffff/55", quotient, remainder);
    end
    saw_busy = (busy !== 1'b0);
    repeat (5) begin
      @(posedge clk); #1;
      if (busy !== 1'b0 || fin !== 1'b1) saw_busy = 1'b1;
    end
    checks++;
    if (saw_busy) begin
      errors++; $display("FAIL dbz_busy: got busy asserted or fin dropped, expected busy=0 fin=1");
    end
  endtask

  task automatic test_extremes();
    int cyc; bit to;
    issue(32'hFFFF_FFFF, 1);
    wait_fin(100, cyc, to);
    checks++;
    if (to || quotient !== 32'hFFFF_FFFF || remainder !== 0 || dbz !== 1'b0) begin
      errors++; $display("FAIL ext_div1: got q=%0h r=%0h dbz=%b expected ffffffff/0/0", quotient, remainder, dbz);
    end
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_fin(100, cyc, to);
    checks++;
    if (to || quotient !== 1 || remainder !== 0) begin
      errors++; $display("FAIL ext_self: got q=%0h r=%0h expected 1/0", quotient, remainder);
    end
  endtask

  task automatic test_busy_ignore();
    int cyc; bit to; bit bad;
    issue(182, 13);
    repeat (10) @(posedge clk);
    @(negedge clk);
    start = 1'b1; dividend = 40; divisor = 3;
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || fin !== 1'b0) begin
      errors++; $display("FAIL busy_ignore_state: got busy=%b fin=%b expected 1/0", busy, fin);
    end
    wait_fin(100, cyc, to);
    checks++;
    if (to || cyc + 11 != W) begin
      errors++; $display("FAIL busy_ignore_latency: got %0d cycles expected %0d", cyc + 11, W);
    end
    checks++;
    if (quotient !== 14 || remainder !== 0) begin
      errors++; $display("FAIL busy_ignore_result: got q=%0d r=%0d expected 14/0", quotient, remainder);
    end
    bad = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (fin !== 1'b1 || busy !== 1'b0 || quotient !== 14) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++; $display("FAIL busy_ignore_extra: got restart after completion expected hold 14 r0");
    end
  endtask

  task automatic test_mid_reset();
    int cyc; bit to; bit bad;
    issue(182, 13);
    repeat (15) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checks++;
    if ({busy, fin, dbz} !== 3'b000 || quotient !== '0 || remainder !== '0) begin
      errors++; $display("FAIL midreset_clear: got flags=%b q=%0h r=%0h expected all 0",
                         {busy, fin, dbz}, quotient, remainder);
    end
    bad = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (fin !== 1'b0 || busy !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++; $display("FAIL midreset_idle: got activity after reset expected idle");
    end
    issue(100, 7);
    wait_fin(100, cyc, to);
    checks++;
    if (to || cyc != W || quotient !== 14 || remainder !== 2) begin
      errors++; $display("FAIL midreset_after: got q=%0d r=%0d cycles=%0d expected 14/2/%0d",
                         quotient, remainder, cyc, W);
    end
  endtask

  task automatic test_back_to_back();
    int cyc; bit to;
    logic [W-1:0] a, b, eq, er;
    logic ez;
    @(negedge clk);
    start = 1'b1;
    for (int k = 0; k < 4; k++) begin
      a = $urandom;
      b = (k[0]) ? $urandom_range(1, 1000) : $urandom;
      if (b == 0) b = 1;
      dividend = a; divisor = b;
      model(a, b, eq, er, ez);
      @(posedge clk); #1;
      checks++;
      if (busy !== 1'b1 || fin !== 1'b0) begin
        errors++; $display("FAIL b2b_accept[%0d]: got busy=%b fin=%b expected 1/0", k, busy, fin);
      end
      wait_fin(100, cyc, to);
      checks++;
      if (to || cyc != W || quotient !== eq || remainder !== er || dbz !== ez) begin
        errors++; $display("FAIL b2b_result[%0d]: got q=%0h r=%0h cycles=%0d expected %0h/%0h/%0d",
                           k, quotient, remainder, cyc, eq, er, W);
      end
    end
    start = 1'b0;
  endtask

  task automatic test_random();
    int cyc; bit to;
    logic [W-1:0] a, b, eq, er;
    logic ez;
    for (int n = 0; n < 1000; n++) begin
      a = $urandom;
      case ($urandom_range(0, 9))
        0:       b = '0;
        1, 2:    b = $urandom_range(1, 15);
        3:       b = a + $urandom_range(1, 100);
        4:       b = a;
        default: b = $urandom >> $urandom_range(0, 31);
      endcase
      model(a, b, eq, er, ez);
      issue(a, b);
      wait_fin(100, cyc, to);
      checks++;
      if (to || quotient !== eq || remainder !== er || dbz !== ez) begin
        errors++; $display("FAIL random[%0d] %0h/%0h: got q=%0h r=%0h dbz=%b timeout=%0d expected %0h/%0h/%b",
                           n, a, b, quotient, remainder, dbz, to, eq, er, ez);
      end
    end
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
    test_reset();
    test_basic();
    test_small();
    test_dbz();
    test_extremes();
    test_busy_ignore();
    test_mid_reset();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
